// File: rtl/spi_flash_responder_pkg.sv
// spi_flash_pkg: shared types and constants for the SPI flash responder.
//   state_t  - responder protocol state
//   CMD_*    - supported flash opcodes
package spi_flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    ID,
    STAT,
    IGNORE
  } state_t;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDID = 8'h9F;
  localparam logic [7:0] CMD_RDSR = 8'h05;

endpackage

// File: rtl/spi_flash_responder_if.sv
// spi_flash_if: SPI bus between the flash-interface master and the responder.
//   sclk, cs_n, mosi - driven by the master
//   miso, miso_oe    - driven by the responder
interface spi_flash_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sclk, cs_n, mosi, input miso, miso_oe);
  modport slave  (input sclk, cs_n, mosi, output miso, miso_oe);
endinterface

// File: rtl/spi_flash_responder_in_sync.sv
// spi_in_sync: 2-FF synchroniser for an asynchronous input plus a third
// flop for edge detection.
//   clk, reset_n - core clock, async active-low reset
//   d            - asynchronous input
//   q            - synchronised level (second flop)
//   rise, fall   - single-cycle edge strobes of q
module spi_in_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 target emulating a serial flash for
// READ (0x03), RDID (0x9F) and RDSR (0x05), backed by a byte-wide memory.
//   clk, reset_n - core clock (>= 8x sclk), async active-low reset
//   spi          - SPI bus (slave side)
//   mem_req_o    - single-cycle read strobe
//   mem_addr_o   - read byte address, held until the next request
//   mem_rdata_i  - read data, valid 1 clk after mem_req_o
//   busy_o       - high while the (synchronised) select is low
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int unsigned ADDR_W   = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016,
  parameter logic [7:0]  STATUS   = 8'h00
) (
  input  logic              clk,
  input  logic              reset_n,
  spi_flash_if.slave        spi,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              busy_o
);
  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic mosi_q, mosi_rise, mosi_fall;

  spi_in_sync #(.RST_VAL(1'b0)) u_sclk (.clk(clk), .reset_n(reset_n), .d(spi.sclk),
    .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  // cs_n flops reset to "selected" so a select already low when reset
  // releases never produces a fall strobe: we only join fresh transfers.
  spi_in_sync #(.RST_VAL(1'b0)) u_cs (.clk(clk), .reset_n(reset_n), .d(spi.cs_n),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall));
  spi_in_sync #(.RST_VAL(1'b0)) u_mosi (.clk(clk), .reset_n(reset_n), .d(spi.mosi),
    .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));

  logic unused_sync;
  assign unused_sync = ^{sclk_q, cs_rise, mosi_rise, mosi_fall};

  state_t      state, state_n;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_cnt;   // bytes into ADDR / ID phase, saturates at 3
  logic [22:0] rx_sh;
  logic [7:0]  tx_sh;
  logic        rvld;       // mem_rdata_i valid this cycle
  logic        armed;      // select seen high since reset
  logic        miso_q, oe_q;

  logic [23:0] rx_nxt;
  logic        byte_end, data_st;

  assign rx_nxt   = {rx_sh, mosi_q};
  assign byte_end = sclk_rise && (bit_cnt == 3'd7);
  assign data_st  = (state == DATA) || (state == ID) || (state == STAT);

  assign spi.miso    = miso_q;
  assign spi.miso_oe = oe_q;
  assign busy_o      = ~cs_q & armed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (cs_fall) state_n = CMD;
      CMD: if (byte_end) begin
        unique case (rx_nxt[7:0])
          CMD_READ: state_n = ADDR;
          CMD_RDID: state_n = ID;
          CMD_RDSR: state_n = STAT;
          default:  state_n = IGNORE;
        endcase
      end
      ADDR: if (byte_end && byte_cnt == 2'd2) state_n = DATA;
      default: ;
    endcase
    if (cs_q) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      rx_sh      <= '0;
      tx_sh      <= '0;
      rvld       <= 1'b0;
      armed      <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
    end else begin
      mem_req_o <= 1'b0;
      rvld      <= mem_req_o;
      if (cs_q) armed <= 1'b1;
      if (cs_q) begin
        // deselect: drop partial byte and any pending prefetch
        bit_cnt <= '0;
        miso_q  <= 1'b0;
        oe_q    <= 1'b0;
      end else if (state == IDLE) begin
        // sclk edges here are ignored, including one coincident with cs fall
        if (cs_fall) begin
          bit_cnt  <= '0;
          byte_cnt <= '0;
        end
      end else begin
        if (sclk_rise) begin
          rx_sh   <= rx_nxt[22:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7 && byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
        end
        if (sclk_fall && data_st) begin
          miso_q <= tx_sh[7];
          tx_sh  <= {tx_sh[6:0], 1'b0};
          oe_q   <= 1'b1;
        end
        unique case (state)
          CMD: if (byte_end) begin
            byte_cnt <= '0;
            if (rx_nxt[7:0] == CMD_RDID)      tx_sh <= JEDEC_ID[23:16];
            else if (rx_nxt[7:0] == CMD_RDSR) tx_sh <= STATUS;
          end
          ADDR: if (byte_end && byte_cnt == 2'd2) begin
            mem_addr_o <= rx_nxt[ADDR_W-1:0];
            mem_req_o  <= 1'b1;
          end
          DATA: begin
            if (rvld) tx_sh <= mem_rdata_i;
            // prefetch the next byte while the current one's last bit is out
            if (byte_end) begin
              mem_addr_o <= mem_addr_o + ADDR_W'(1);
              mem_req_o  <= 1'b1;
            end
          end
          ID: if (byte_end) begin
            unique case (byte_cnt)
              2'd0:    tx_sh <= JEDEC_ID[15:8];
              2'd1:    tx_sh <= JEDEC_ID[7:0];
              default: tx_sh <= 8'h00;
            endcase
          end
          STAT: if (byte_end) tx_sh <= STATUS;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a second instance with STATUS=8'hA5
// shares the SPI stimulus; expected bytes/addresses go to queues and are
// compared against what the master sees on MISO and the memory port.
module tb_spi_flash_responder;
  import spi_flash_pkg::*;

  logic clk = 1'b0, reset_n = 1'b0;
  logic sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  always #5 clk = ~clk;

  spi_flash_if spi0();
  spi_flash_if spi1();
  assign spi0.sclk = sclk; assign spi0.cs_n = cs_n; assign spi0.mosi = mosi;
  assign spi1.sclk = sclk; assign spi1.cs_n = cs_n; assign spi1.mosi = mosi;

  logic        mem_req0, mem_req1, busy0, busy1;
  logic [23:0] mem_addr0, mem_addr1;
  logic [7:0]  rdata0, rdata1;

  spi_flash_responder dut (.clk(clk), .reset_n(reset_n), .spi(spi0),
    .mem_req_o(mem_req0), .mem_addr_o(mem_addr0), .mem_rdata_i(rdata0), .busy_o(busy0));
  spi_flash_responder #(.STATUS(8'hA5)) dut_a5 (.clk(clk), .reset_n(reset_n), .spi(spi1),
    .mem_req_o(mem_req1), .mem_addr_o(mem_addr1), .mem_rdata_i(rdata1), .busy_o(busy1));

  // memory holds address-as-data; junk on cycles without a request
  always @(posedge clk) begin
    rdata0 <= mem_req0 ? mem_addr0[7:0] : 8'($urandom);
    rdata1 <= mem_req1 ? mem_addr1[7:0] : 8'($urandom);
  end

  logic [23:0] req_q[$];
  int          consec = 0;
  logic        prev_req = 1'b0;
  always @(negedge clk) begin
    if (mem_req0) begin
      req_q.push_back(mem_addr0);
      if (prev_req) consec++;
    end
    prev_req = mem_req0;
  end

  logic [7:0]  exp_q[$], got_q[$];
  logic [23:0] exp_addr_q[$];
  int n_assert = 0, n_fail = 0, oe_bad = 0;
  bit mon_sel = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sel_lo();
    req_q.delete();
    cs_n = 1'b0; #160;
    chk("busy_sel", 32'(busy0), 32'd1);
  endtask

  task automatic sel_hi();
    #80; cs_n = 1'b1; #160;
    chk("busy_desel", 32'(busy0), 32'd0);
  endtask

  task automatic shift_bits(input logic [7:0] tx, input int nbits, input bit exp_oe, input bit cap);
    logic [7:0] rx;
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i]; #80;
      rx[i] = mon_sel ? spi1.miso : spi0.miso;
      if ((mon_sel ? spi1.miso_oe : spi0.miso_oe) !== exp_oe) oe_bad++;
      sclk = 1'b1; #80; sclk = 1'b0;
    end
    if (cap) got_q.push_back(rx);
  endtask

  task automatic txn(input logic [7:0] cmd, input bit has_addr, input logic [23:0] addr,
                     input int nb, input bit exp_oe);
    sel_lo();
    shift_bits(cmd, 8, 1'b0, 1'b0);
    if (has_addr) for (int b = 2; b >= 0; b--) shift_bits(addr[8*b +: 8], 8, 1'b0, 1'b0);
    for (int k = 0; k < nb; k++) shift_bits(8'h00, 8, exp_oe, exp_oe);
    sel_hi();
  endtask

  task automatic sb_check(input string tag);
    chk({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) chk(tag, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete(); exp_q.delete();
    chk({tag, "_oe_phase"}, oe_bad, 0);
    oe_bad = 0;
    chk({tag, "_oe_idle"}, 32'(spi0.miso_oe), 32'd0);
    chk({tag, "_miso_idle"}, 32'(spi0.miso), 32'd0);
  endtask

  task automatic addr_check(input string tag);
    chk({tag, "_nreq"}, 32'(req_q.size()), 32'(exp_addr_q.size()));
    while (req_q.size() > 0 && exp_addr_q.size() > 0) chk(tag, 32'(req_q.pop_front()), 32'(exp_addr_q.pop_front()));
    req_q.delete(); exp_addr_q.delete();
  endtask

  task automatic push_read(input logic [23:0] a, input int nb);
    for (int i = 0; i <= nb; i++) begin
      if (i < nb) exp_q.push_back(8'(a + 24'(i)));
      exp_addr_q.push_back(a + 24'(i));
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_miso"}, 32'(spi0.miso), 32'd0);
    chk({tag, "_oe"}, 32'(spi0.miso_oe), 32'd0);
    chk({tag, "_req"}, 32'(mem_req0), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr0), 32'd0);
    chk({tag, "_busy"}, 32'(busy0), 32'd0);
    chk({tag, "_state"}, 32'(dut.state), 32'(IDLE));
  endtask

  initial begin
    #22;
    chk_reset_outs("rst");
    reset_n = 1'b1; #100;

    push_read(24'h000010, 4);
    txn(CMD_READ, 1'b1, 24'h000010, 4, 1'b1);
    sb_check("read10"); addr_check("read10_addr");

    exp_q.push_back(8'hEF); exp_q.push_back(8'h40); exp_q.push_back(8'h16); exp_q.push_back(8'h00);
    txn(CMD_RDID, 1'b0, 24'h0, 4, 1'b1);
    sb_check("rdid");

    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    txn(CMD_RDSR, 1'b0, 24'h0, 2, 1'b1);
    sb_check("rdsr00");
    mon_sel = 1'b1;
    exp_q.push_back(8'hA5); exp_q.push_back(8'hA5);
    txn(CMD_RDSR, 1'b0, 24'h0, 2, 1'b1);
    sb_check("rdsrA5");
    mon_sel = 1'b0;

    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    exp_addr_q.push_back(24'hFFFFFF); exp_addr_q.push_back(24'h000000);
    exp_addr_q.push_back(24'h000001);
    txn(CMD_READ, 1'b1, 24'hFFFFFF, 2, 1'b1);
    sb_check("readwrap"); addr_check("readwrap_addr");

    txn(8'h5A, 1'b0, 24'h0, 2, 1'b0);
    sb_check("ignore");
    chk("ignore_nreq", 32'(req_q.size()), 32'd0);
    push_read(24'h000020, 1);
    txn(CMD_READ, 1'b1, 24'h000020, 1, 1'b1);
    sb_check("read20"); addr_check("read20_addr");

    // abort 3 bits into the second data byte
    exp_q.push_back(8'h30);
    sel_lo();
    shift_bits(CMD_READ, 8, 1'b0, 1'b0);
    for (int b = 2; b >= 0; b--) shift_bits(8'(24'h000030 >> (8*b)), 8, 1'b0, 1'b0);
    shift_bits(8'h00, 8, 1'b1, 1'b1);
    shift_bits(8'h00, 3, 1'b1, 1'b0);
    sel_hi();
    chk("abort_state", 32'(dut.state), 32'(IDLE));
    sb_check("abort");
    exp_q.push_back(8'hEF); exp_q.push_back(8'h40); exp_q.push_back(8'h16); exp_q.push_back(8'h00);
    txn(CMD_RDID, 1'b0, 24'h0, 4, 1'b1);
    sb_check("rdid_after_abort");

    // reset pulse mid-address; the running transfer must not be joined
    sel_lo();
    shift_bits(CMD_READ, 8, 1'b0, 1'b0);
    shift_bits(8'h00, 8, 1'b0, 1'b0);
    shift_bits(8'h00, 4, 1'b0, 1'b0);
    reset_n = 1'b0; #2;
    chk_reset_outs("midrst");
    #40; reset_n = 1'b1;
    shift_bits(8'h00, 4, 1'b0, 1'b0);
    shift_bits(8'h45, 8, 1'b0, 1'b0);
    shift_bits(8'h00, 8, 1'b0, 1'b0);
    chk("midrst_nreq", 32'(req_q.size()), 32'd0);
    chk("midrst_busy", 32'(busy0), 32'd0);
    #80; cs_n = 1'b1; #160;
    sb_check("midrst");
    push_read(24'h000045, 2);
    txn(CMD_READ, 1'b1, 24'h000045, 2, 1'b1);
    sb_check("read45"); addr_check("read45_addr");

    chk("req_consecutive", consec, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- SPI mode-0 responder (target) that answers the SoC's flash-interface master, standing in for the external SPI flash.
- It is used on the FPGA top and in system simulation so the boot path can be exercised without a physical flash part.
- It serves the READ (0x03), RDID (0x9F) and RDSR (0x05) commands from a byte-wide synchronous memory port.
- All SPI inputs are oversampled in the core clock domain.

Parameters:
- ADDR_W, 24: flash byte-address width; mem_addr_o width. Legal range 8..24.
- JEDEC_ID, 24'hEF4016: manufacturer/type/capacity bytes returned by RDID, MSB byte first.
- STATUS, 8'h00: byte returned by RDSR (never busy).

Ports:
- clk  in  1  core clock; must be at least 8x sclk_i frequency.
- reset_n  in  1  asynchronous, active-low reset.
- sclk_i  in  1  SPI serial clock from master; asynchronous to clk.
- cs_n_i  in  1  slave select, active low; asynchronous.
- mosi_i  in  1  master-out data; asynchronous.
- miso_o  out  1  slave-out data.
- miso_oe_o  out  1  MISO output enable; 1 only while selected and in a data phase.
- mem_req_o  out  1  single-cycle read strobe.
- mem_addr_o  out  ADDR_W  byte address for the read; held until the next request.
- mem_rdata_i  in  8  read data, valid exactly 1 clk after mem_req_o.
- busy_o  out  1  high while cs_n (synchronised) is low.

Behaviour:
- Reset values (asynchronous): miso_o=0, miso_oe_o=0, mem_req_o=0, mem_addr_o=0, busy_o=0, state=IDLE.
- Input synchronisation:
  - sclk_i, cs_n_i and mosi_i each pass through a 2-FF synchroniser.
  - Rise/fall strobes are derived from a third sclk flop.
  - A cs_n fall strobe is derived from a third cs_n flop.
- Shifting (mode 0, MSB first):
  - MOSI is sampled on the detected sclk rise.
  - MISO is updated on the detected sclk fall.
  - A 3-bit bit counter increments on each rise and wraps 7->0; wrap marks a byte boundary.
- States:
  - IDLE: wait for cs_n fall; then clear the bit counter and go to CMD.
  - CMD: after 8 bits, decode the command byte.
    - 0x03 -> ADDR.
    - 0x9F -> ID, with the first ID byte loaded into the tx shifter.
    - 0x05 -> STAT.
    - Any other value -> IGNORE.
  - ADDR: shift 24 bits.
    - Only the low ADDR_W bits are kept; upper bits are discarded.
    - On the 24th rise, issue mem_req_o with that address; go to DATA.
  - DATA:
    - On mem_rdata_i valid, load the tx shifter.
    - At each byte boundary, advance the address by 1 (modulo 2^ADDR_W, so all-ones wraps to 0) and issue the next mem_req_o.
    - The prefetched byte is loaded before the next fall strobe.
  - ID: return JEDEC_ID[23:16], then [15:8], then [7:0]; return 8'h00 for every subsequent byte.
  - STAT: return STATUS repeatedly for every byte.
  - IGNORE: miso_oe_o=0; consume bits until deselect.
- MISO timing:
  - The first data bit of each response is driven on the first sclk fall after the last command/address bit.
  - miso_oe_o rises at that same fall and stays high until deselect.
  - miso_o reflects the tx shifter MSB; it shifts left on each fall and is reloaded at each byte boundary.
- Deselect (cs_n synchronised high) in any state, including mid-byte:
  - Return to IDLE on the next clk.
  - Set miso_oe_o=0 and miso_o=0.
  - Discard any partial byte; an outstanding prefetch result is ignored.
- Simultaneous cs_n fall and sclk edge: the cs_n fall takes priority. The sclk edge is ignored because mode-0 masters hold sclk low at select.
- mem_req_o is never asserted outside ADDR/DATA and never on two consecutive cycles.
- Reset mid-transfer: outputs return to reset values immediately. The responder re-arms only on a fresh cs_n fall after reset_n rises; it does not join a transfer already in progress.

Decomposition:
- Package spi_flash_pkg: state enum (IDLE, CMD, ADDR, DATA, ID, STAT, IGNORE) and command constants CMD_READ=8'h03, CMD_RDID=8'h9F, CMD_RDSR=8'h05.
- One sub-module, spi_in_sync: 3-flop synchroniser plus edge detector, instantiated once each for sclk and cs_n. mosi uses only the 2-FF stage of the same module.

Test Plan:
- READ from 0x000010, memory holds address-as-data, clocked for 4 data bytes:
  - MISO yields 0x10, 0x11, 0x12, 0x13.
  - mem_addr_o steps 0x10..0x14 (includes the prefetch).
  - miso_oe_o is high only during the data phase.
- RDID with default JEDEC_ID, 4 bytes clocked: MISO yields 0xEF, 0x40, 0x16, 0x00.
- RDSR with STATUS=8'h00, then with STATUS overridden to 8'hA5, 2 bytes clocked: MISO yields 0xA5, 0xA5.
- READ at address 0xFFFFFF (ADDR_W=24), 2 bytes clocked: mem_addr_o goes 0xFFFFFF then 0x000000, and MISO carries the matching memory bytes.
- Command 0x5A followed by 16 clocks: miso_oe_o stays 0 and mem_req_o never asserts. Then deselect, and a new READ from 0x000020 returns 0x20.
- Abort cases:
  - Deselect after 3 bits of the second READ data byte: miso_oe_o falls and state returns to IDLE; a following RDID is correct.
  - reset_n pulsed mid-address: all outputs are at reset values, and the next transaction returns correct data.
